// File: rtl/cnn_uart_pkg.sv
// Shared types and constants for the classifier result UART.
package cnn_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int DEFAULT_BAUD_DIV = 434;

    // Digits 0..9 map to '0'..'9'; anything else is reported as '?'.
    function automatic logic [7:0] ascii_digit(input logic [7:0] value);
        return (value <= 8'd9) ? 8'(ASCII_ZERO + value) : ASCII_QMARK;
    endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Result handshake and serial line between the classifier/sequencer and the UART.
interface result_uart_tx_if;

    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       busy;
    logic       tx_done;

    modport master (
        output trmt,
        output tx_data,
        input  TX,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  trmt,
        input  tx_data,
        output TX,
        output busy,
        output tx_done
    );

endinterface

// File: rtl/uart_tx_core.sv
// Bit-level 8N1 serialiser. A load in IDLE, or in the last stop-bit cycle, starts a frame.
//
// state | meaning
// IDLE  | line high, waiting for load
// START | start bit (0) for BAUD_DIV cycles
// DATA  | 8 data bits, LSB first, bit_cnt selects the bit
// STOP  | stop bit (1); stop_end marks its final cycle
module uart_tx_core
    import cnn_uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       stop_end
);

    localparam logic [11:0] RELOAD = 12'(BAUD_DIV - 1);

    tx_state_t   state, state_d;
    logic [11:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [8:0]  shift_q, shift_d;
    logic        tx_d;
    logic        expire;

    assign expire   = (baud_q == 12'd0);
    assign stop_end = (state == STOP) && expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud_q  <= 12'd0;
            bit_q   <= 3'd0;
            shift_q <= 9'd0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    baud_d  = RELOAD;
                    shift_d = {data, 1'b0};
                end
            end
            START: begin
                if (expire) begin
                    state_d = DATA;
                    baud_d  = RELOAD;
                    bit_d   = 3'd0;
                    shift_d = {1'b1, shift_q[8:1]};
                end else begin
                    baud_d = baud_q - 12'd1;
                end
            end
            DATA: begin
                if (expire) begin
                    baud_d = RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b1, shift_q[8:1]};
                    end
                end else begin
                    baud_d = baud_q - 12'd1;
                end
            end
            STOP: begin
                if (expire) begin
                    baud_d = RELOAD;
                    // Back-to-back frame: next start bit follows the stop bit directly.
                    if (load) begin
                        state_d = START;
                        shift_d = {data, 1'b0};
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_d = ((state_d == IDLE) || (state_d == STOP)) ? 1'b1 : shift_d[0];
    end

endmodule

// File: rtl/result_uart_tx.sv
// Sends the classified digit over the UART and raises a sticky tx_done when it has left.
// RESULT_ASCII_EN: send ASCII digit + CR + LF as one back-to-back message instead of the raw byte.
module result_uart_tx
    import cnn_uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    result_uart_tx_if.slave  bus
);

    logic       busy_q;
    logic       done_q;
    logic       accept;
    logic       stop_end;
    logic       load;
    logic       finish;
    logic [7:0] load_data;
    logic       tx;

    assign accept = bus.trmt && !busy_q;

`ifdef RESULT_ASCII_EN
    logic [1:0] idx_q;
    logic       more;

    assign more      = stop_end && (idx_q != 2'd2);
    assign finish    = stop_end && !more;
    assign load      = accept || more;
    assign load_data = accept ? ascii_digit(bus.tx_data)
                              : ((idx_q == 2'd0) ? ASCII_CR : ASCII_LF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
        end else if (accept) begin
            idx_q <= 2'd0;
        end else if (more) begin
            idx_q <= idx_q + 2'd1;
        end
    end
`else
    assign finish    = stop_end;
    assign load      = accept;
    assign load_data = bus.tx_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (accept) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (finish) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
        end
    end

    uart_tx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data     (load_data),
        .tx       (tx),
        .stop_end (stop_end)
    );

    assign bus.TX      = tx;
    assign bus.busy    = busy_q;
    assign bus.tx_done = done_q;

endmodule
